// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave arbiter for the sram-like bus.
// In-order ID queue steers each slave data_ok/rdata back to its issuing master.
module sram_like_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       inst_req,
    input  logic                       inst_wr,
    input  logic [1:0]                 inst_size,
    input  logic [31:0]                inst_addr,
    input  logic [31:0]                inst_wdata,
    output logic [31:0]                inst_rdata,
    output logic                       inst_addr_ok,
    output logic                       inst_data_ok,
    input  logic                       data_req,
    input  logic                       data_wr,
    input  logic [1:0]                 data_size,
    input  logic [31:0]                data_addr,
    input  logic [31:0]                data_wdata,
    output logic [31:0]                data_rdata,
    output logic                       data_addr_ok,
    output logic                       data_data_ok,
    output logic                       s_req,
    output logic                       s_wr,
    output logic [1:0]                 s_size,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    input  logic [31:0]                s_rdata,
    input  logic                       s_addr_ok,
    input  logic                       s_data_ok,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       err_unexpected
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic          ID_INST    = 1'b0;
    localparam logic          ID_DATA    = 1'b1;

    logic              ready_r;
    logic              lock_r;
    logic              lock_id_r;
    logic [SW-1:0]     starve_r;
    logic [DEPTH-1:0]  q_r;
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;
    logic              err_r;

    logic              active_s;
    logic              full_s;
    logic              sel_s;
    logic              sel_req_s;
    logic              accept_s;
    logic              pop_s;
    logic              head_s;
    logic              spurious_s;

    // Grant selection, slave request mux and address handshake
    always_comb begin
        active_s = resetn & ready_r;
        full_s   = (count_r == FULL_CNT);
        if (lock_r) begin
            sel_s = lock_id_r;
        end else if (data_req && !(inst_req && (starve_r == STARVE_MAX))) begin
            sel_s = ID_DATA;
        end else begin
            sel_s = ID_INST;
        end
        sel_req_s = (sel_s == ID_DATA) ? data_req : inst_req;
        s_req     = active_s & ~full_s & sel_req_s;
        accept_s  = s_req & s_addr_ok;
        if (sel_s == ID_DATA) begin
            s_wr    = data_wr;
            s_size  = data_size;
            s_addr  = data_addr;
            s_wdata = data_wdata;
        end else begin
            s_wr    = inst_wr;
            s_size  = inst_size;
            s_addr  = inst_addr;
            s_wdata = inst_wdata;
        end
        inst_addr_ok = accept_s & (sel_s == ID_INST);
        data_addr_ok = accept_s & (sel_s == ID_DATA);
    end

    // Return-path steering from the head of the ID queue
    always_comb begin
        pop_s        = resetn & s_data_ok & (count_r != {(AW + 1){1'b0}});
        spurious_s   = resetn & s_data_ok & (count_r == {(AW + 1){1'b0}});
        head_s       = q_r[rd_ptr_r];
        inst_data_ok = pop_s & (head_s == ID_INST);
        data_data_ok = pop_s & (head_s == ID_DATA);
        inst_rdata   = inst_data_ok ? s_rdata : 32'h0000_0000;
        data_rdata   = data_data_ok ? s_rdata : 32'h0000_0000;
        outstanding  = count_r;
        err_unexpected = err_r;
    end

    // Requests are held off for one cycle after reset release
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b1;
        end
    end

    // A stalled request pins the grant so payload never switches mid-request
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_r    <= 1'b0;
            lock_id_r <= 1'b0;
        end else if (accept_s) begin
            lock_r    <= 1'b0;
        end else if (s_req) begin
            lock_r    <= 1'b1;
            lock_id_r <= sel_s;
        end else begin
            lock_r    <= lock_r;
        end
    end

    // Count data grants taken while inst waits
    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve_r <= {SW{1'b0}};
        end else if (inst_addr_ok || !inst_req) begin
            starve_r <= {SW{1'b0}};
        end else if (data_addr_ok && (starve_r != STARVE_MAX)) begin
            starve_r <= starve_r + SW'(1'b1);
        end else begin
            starve_r <= starve_r;
        end
    end

    // In-order ID queue of accepted transactions
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q_r      <= {DEPTH{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (accept_s) begin
                q_r[wr_ptr_r] <= sel_s;
                wr_ptr_r      <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1'b1);
                2'b01:   count_r <= count_r - (AW + 1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky flag for a return with nothing in flight
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_r <= 1'b0;
        end else if (spurious_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed-vector bench for sram_like_arbiter (DEPTH=4, STARVE_LIMIT=3).
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, s_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        s_req, s_wr, s_addr_ok, s_data_ok;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [2:0]  outstanding;
    logic        err_unexpected;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok), .outstanding(outstanding),
        .err_unexpected(err_unexpected)
    );

    task automatic idle_inputs();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2;
        data_addr = 32'h0; data_wdata = 32'h0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        @(negedge clk);
        inst_req = 1'b1; data_req = 1'b1; s_addr_ok = 1'b1;
        #1;
        if (s_req !== 1'b0) begin $display("FAIL rst_s_req got=%0h exp=0", s_req); errs++; end vecs++;
        if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin $display("FAIL rst_addr_ok got=%0h%0h exp=00", inst_addr_ok, data_addr_ok); errs++; end vecs++;
        if (outstanding !== 3'd0) begin $display("FAIL rst_outstanding got=%0d exp=0", outstanding); errs++; end vecs++;
        if (err_unexpected !== 1'b0) begin $display("FAIL rst_err got=%0h exp=0", err_unexpected); errs++; end vecs++;
        @(negedge clk);
        idle_inputs();
        resetn = 1'b1;
        #1;
        if (s_req !== 1'b0 || outstanding !== 3'd0) begin $display("FAIL rst_after got=%0h/%0d exp=0/0", s_req, outstanding); errs++; end vecs++;
        @(negedge clk);
    endtask

    task automatic test_inst_only();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; s_addr_ok = 1'b1;
        #1;
        if (inst_addr_ok !== 1'b1) begin $display("FAIL io_iaddr_ok got=%0h exp=1", inst_addr_ok); errs++; end vecs++;
        if (s_addr !== 32'hBFC0_0000) begin $display("FAIL io_s_addr got=%08h exp=bfc00000", s_addr); errs++; end vecs++;
        @(negedge clk);
        idle_inputs();
        s_data_ok = 1'b1; s_rdata = 32'h3C08_0001;
        #1;
        if (outstanding !== 3'd1) begin $display("FAIL io_out1 got=%0d exp=1", outstanding); errs++; end vecs++;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin $display("FAIL io_data_ok got=%0h%0h exp=10", inst_data_ok, data_data_ok); errs++; end vecs++;
        if (inst_rdata !== 32'h3C08_0001) begin $display("FAIL io_rdata got=%08h exp=3c080001", inst_rdata); errs++; end vecs++;
        @(negedge clk);
        idle_inputs();
        #1;
        if (outstanding !== 3'd0) begin $display("FAIL io_out0 got=%0d exp=0", outstanding); errs++; end vecs++;
        if (inst_rdata !== 32'h0) begin $display("FAIL io_rdata_idle got=%08h exp=0", inst_rdata); errs++; end vecs++;
        @(negedge clk);
    endtask

    task automatic test_both_request();
        inst_req = 1'b1; inst_addr = 32'h0000_1000;
        data_req = 1'b1; data_addr = 32'h8000_0040; data_wr = 1'b1;
        data_size = 2'd1; data_wdata = 32'hDEAD_BEEF; s_addr_ok = 1'b1;
        #1;
        if (s_addr !== 32'h8000_0040 || data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
            $display("FAIL both_first got=%08h/%0h%0h exp=80000040/10", s_addr, data_addr_ok, inst_addr_ok); errs++; end vecs++;
        if (s_wr !== 1'b1 || s_wdata !== 32'hDEAD_BEEF || s_size !== 2'd1) begin
            $display("FAIL both_payload got=%0h/%08h/%0d exp=1/deadbeef/1", s_wr, s_wdata, s_size); errs++; end vecs++;
        @(negedge clk);
        data_req = 1'b0;
        #1;
        if (s_addr !== 32'h0000_1000 || inst_addr_ok !== 1'b1 || s_wr !== 1'b0) begin
            $display("FAIL both_second got=%08h/%0h/%0h exp=00001000/1/0", s_addr, inst_addr_ok, s_wr); errs++; end vecs++;
        @(negedge clk);
        idle_inputs();
        s_data_ok = 1'b1; s_rdata = 32'h1111_2222;
        #1;
        if (outstanding !== 3'd2) begin $display("FAIL both_out2 got=%0d exp=2", outstanding); errs++; end vecs++;
        if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== 32'h1111_2222) begin
            $display("FAIL both_ret_d got=%0h%0h/%08h exp=10/11112222", data_data_ok, inst_data_ok, data_rdata); errs++; end vecs++;
        @(negedge clk);
        s_rdata = 32'h3333_4444;
        #1;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h3333_4444 || data_rdata !== 32'h0) begin
            $display("FAIL both_ret_i got=%0h%0h/%08h/%08h exp=10/33334444/0", inst_data_ok, data_data_ok, inst_rdata, data_rdata); errs++; end vecs++;
        @(negedge clk);
        idle_inputs();
        #1;
        if (outstanding !== 3'd0) begin $display("FAIL both_out0 got=%0d exp=0", outstanding); errs++; end vecs++;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        logic [7:0] gseq;
        gseq = 8'b0111_0111;   // bit k = 1 -> data granted in cycle k
        for (int k = 0; k < 8; k++) begin
            inst_req = 1'b1; data_req = 1'b1; s_addr_ok = 1'b1;
            s_data_ok = (k != 0);
            #1;
            if (data_addr_ok !== gseq[k] || inst_addr_ok !== !gseq[k]) begin
                $display("FAIL starve_grant%0d got=d%0h/i%0h exp=d%0h", k, data_addr_ok, inst_addr_ok, gseq[k]); errs++; end vecs++;
            if (k != 0) begin
                if (data_data_ok !== gseq[k-1] || inst_data_ok !== !gseq[k-1]) begin
                    $display("FAIL starve_ret%0d got=d%0h/i%0h exp=d%0h", k, data_data_ok, inst_data_ok, gseq[k-1]); errs++; end vecs++;
            end
            @(negedge clk);
        end
        idle_inputs();
        s_data_ok = 1'b1;
        #1;
        if (inst_data_ok !== 1'b1 || outstanding !== 3'd1) begin
            $display("FAIL starve_last got=%0h/%0d exp=1/1", inst_data_ok, outstanding); errs++; end vecs++;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_lock();
        inst_req = 1'b1; inst_addr = 32'h0000_2000; s_addr_ok = 1'b0;
        #1;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_2000 || inst_addr_ok !== 1'b0) begin
            $display("FAIL lock_c1 got=%0h/%08h/%0h exp=1/00002000/0", s_req, s_addr, inst_addr_ok); errs++; end vecs++;
        @(negedge clk);
        data_req = 1'b1; data_addr = 32'h8000_0100;
        #1;
        if (s_addr !== 32'h0000_2000 || data_addr_ok !== 1'b0) begin
            $display("FAIL lock_c2 got=%08h/%0h exp=00002000/0", s_addr, data_addr_ok); errs++; end vecs++;
        @(negedge clk);
        s_addr_ok = 1'b1;
        #1;
        if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || s_addr !== 32'h0000_2000) begin
            $display("FAIL lock_c3 got=%0h%0h/%08h exp=10/00002000", inst_addr_ok, data_addr_ok, s_addr); errs++; end vecs++;
        @(negedge clk);
        inst_req = 1'b0;
        #1;
        if (data_addr_ok !== 1'b1 || s_addr !== 32'h8000_0100) begin
            $display("FAIL lock_c4 got=%0h/%08h exp=1/80000100", data_addr_ok, s_addr); errs++; end vecs++;
        @(negedge clk);
        idle_inputs();
        s_data_ok = 1'b1;
        #1;
        if (inst_data_ok !== 1'b1 || outstanding !== 3'd2) begin
            $display("FAIL lock_ret_i got=%0h/%0d exp=1/2", inst_data_ok, outstanding); errs++; end vecs++;
        @(negedge clk);
        #1;
        if (data_data_ok !== 1'b1) begin $display("FAIL lock_ret_d got=%0h exp=1", data_data_ok); errs++; end vecs++;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            inst_req = (k % 2 == 0); data_req = (k % 2 == 1); s_addr_ok = 1'b1;
            inst_addr = 32'h0000_3000 + k; data_addr = 32'h8000_3000 + k;
            @(negedge clk);
        end
        inst_req = 1'b0; data_req = 1'b1;
        #1;
        if (outstanding !== 3'd4 || s_req !== 1'b0 || data_addr_ok !== 1'b0) begin
            $display("FAIL full_block got=%0d/%0h/%0h exp=4/0/0", outstanding, s_req, data_addr_ok); errs++; end vecs++;
        @(negedge clk);
        s_data_ok = 1'b1; s_rdata = 32'hA0A0_0001;
        #1;
        if (inst_data_ok !== 1'b1 || s_req !== 1'b0) begin
            $display("FAIL full_pop got=%0h/%0h exp=1/0", inst_data_ok, s_req); errs++; end vecs++;
        @(negedge clk);
        s_data_ok = 1'b0;
        #1;
        if (s_req !== 1'b1 || data_addr_ok !== 1'b1 || outstanding !== 3'd3) begin
            $display("FAIL full_resume got=%0h/%0h/%0d exp=1/1/3", s_req, data_addr_ok, outstanding); errs++; end vecs++;
        @(negedge clk);
        idle_inputs();
        s_data_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (data_data_ok !== (k != 1) || inst_data_ok !== (k == 1)) begin
                $display("FAIL full_route%0d got=d%0h/i%0h exp=d%0h", k, data_data_ok, inst_data_ok, (k != 1)); errs++; end vecs++;
            @(negedge clk);
        end
        s_data_ok = 1'b0;
        #1;
        if (outstanding !== 3'd0) begin $display("FAIL full_drain got=%0d exp=0", outstanding); errs++; end vecs++;
        @(negedge clk);
    endtask

    task automatic test_unexpected();
        s_data_ok = 1'b1;
        #1;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
            $display("FAIL unexp_route got=%0h%0h exp=00", inst_data_ok, data_data_ok); errs++; end vecs++;
        @(negedge clk);
        s_data_ok = 1'b0;
        #1;
        if (err_unexpected !== 1'b1 || outstanding !== 3'd0) begin
            $display("FAIL unexp_set got=%0h/%0d exp=1/0", err_unexpected, outstanding); errs++; end vecs++;
        inst_req = 1'b1; s_addr_ok = 1'b1;
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b1;
        #1;
        if (err_unexpected !== 1'b1) begin $display("FAIL unexp_sticky got=%0h exp=1", err_unexpected); errs++; end vecs++;
        @(negedge clk);
        idle_inputs();
        #1;
        if (outstanding !== 3'd2) begin $display("FAIL unexp_out2 got=%0d exp=2", outstanding); errs++; end vecs++;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        if (outstanding !== 3'd0 || err_unexpected !== 1'b0) begin
            $display("FAIL unexp_reset got=%0d/%0h exp=0/0", outstanding, err_unexpected); errs++; end vecs++;
        @(negedge clk);
        s_data_ok = 1'b1;
        #1;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
            $display("FAIL unexp_dropped got=%0h%0h exp=00", inst_data_ok, data_data_ok); errs++; end vecs++;
        @(negedge clk);
        s_data_ok = 1'b0;
        #1;
        if (err_unexpected !== 1'b1) begin $display("FAIL unexp_dropped_err got=%0h exp=1", err_unexpected); errs++; end vecs++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_inst_only();
        test_both_request();
        test_starvation();
        test_lock();
        test_full();
        test_unexpected();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
